// File: rtl/pio_scan_ctrl_if.sv
`default_nettype none
// pio_scan_ctrl_if: host read request/response plus the PIO read port owned by the scan controller.
interface pio_scan_ctrl_if;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;
  logic        host_req;
  logic [1:0]  host_addr;
  logic        host_ack;
  logic [31:0] host_rdata;

  modport master (
    output pio_address, host_ack, host_rdata,
    input  pio_readdata, host_req, host_addr
  );

  modport slave (
    input  pio_address, host_ack, host_rdata,
    output pio_readdata, host_req, host_addr
  );
endinterface
`default_nettype wire

// File: rtl/pio_scan_ctrl.sv
`default_nettype none
// pio_scan_ctrl: periodic debounced PIO scanner sharing the PIO read port with a host (round-robin).
// Optional build macro PIO_SCAN_IRQ_EN adds a sticky change interrupt register.
module pio_scan_ctrl #(
  parameter int DATA_W   = 4,
  parameter int PERIOD_W = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  pio_scan_ctrl_if.master     bus,
  output logic [DATA_W-1:0]   stable_data,
  output logic                change,
  output logic                overrun,
  output logic                irq,
  input  logic                irq_clr
);
  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN_RD  = 3'd1,
    SCAN_CAP = 3'd2,
    HOST_RD  = 3'd3,
    HOST_CAP = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [PERIOD_W-1:0] per_cnt;
  logic                tick;
  logic                scan_pending;
  logic                last_host;
  logic                grant_scan, grant_host;
  logic                host_req_eff;
  logic                scan_done;
  logic [1:0]          host_addr_q;
  logic [DATA_W-1:0]   sample, last_raw, raw_nx;
  logic [3:0]          db_cnt, db_cnt_nx;
  logic                accept;

  // >= rather than == keeps the counter sane if period shrinks mid-count
  assign tick         = enable && (per_cnt >= period);
  assign scan_done    = (state == SCAN_CAP);
  // The request is still high during the ack cycle; it must not re-grant itself
  assign host_req_eff = bus.host_req && !bus.host_ack;
  assign sample       = bus.pio_readdata[DATA_W-1:0];
  assign bus.pio_address = (state == HOST_RD || state == HOST_CAP) ? host_addr_q : 2'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt <= '0;
    end else if (!enable || tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_pending <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (!enable || scan_done) begin
        scan_pending <= 1'b0;
      end else if (tick) begin
        scan_pending <= 1'b1;
      end
      if (tick && scan_pending) begin
        overrun <= 1'b1;
      end else if (irq_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    grant_scan = 1'b0;
    grant_host = 1'b0;
    case (state)
      IDLE: begin
        if (scan_pending && (!host_req_eff || last_host)) begin
          state_nx   = SCAN_RD;
          grant_scan = 1'b1;
        end else if (host_req_eff) begin
          state_nx   = HOST_RD;
          grant_host = 1'b1;
        end
      end
      SCAN_RD:  state_nx = SCAN_CAP;
      SCAN_CAP: state_nx = IDLE;
      HOST_RD:  state_nx = HOST_CAP;
      HOST_CAP: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_host      <= 1'b1;
      host_addr_q    <= 2'd0;
      bus.host_ack   <= 1'b0;
      bus.host_rdata <= 32'd0;
    end else begin
      state        <= state_nx;
      bus.host_ack <= (state == HOST_CAP);
      if (grant_scan) begin
        last_host <= 1'b0;
      end else if (grant_host) begin
        last_host   <= 1'b1;
        host_addr_q <= bus.host_addr;
      end
      if (state == HOST_CAP) begin
        bus.host_rdata <= bus.pio_readdata;
      end
    end
  end

  always_comb begin
    raw_nx    = last_raw;
    db_cnt_nx = db_cnt;
    if (scan_done) begin
      if (sample == last_raw) begin
        if (db_cnt < DEB_MAX) begin
          db_cnt_nx = db_cnt + 4'd1;
        end
      end else begin
        raw_nx    = sample;
        db_cnt_nx = 4'd1;
      end
    end
  end

  // Acceptance uses the post-capture count so change lands the cycle after the capture
  assign accept = scan_done && (db_cnt_nx == DEB_MAX) && (raw_nx != stable_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_raw    <= '0;
      db_cnt      <= 4'd0;
      stable_data <= '0;
      change      <= 1'b0;
    end else begin
      last_raw <= raw_nx;
      db_cnt   <= db_cnt_nx;
      change   <= accept;
      if (accept) begin
        stable_data <= raw_nx;
      end
    end
  end

`ifdef PIO_SCAN_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (accept) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pio_scan_ctrl.sv
`default_nettype none
// tb_pio_scan_ctrl: directed vectors for scan timing, debounce, arbitration, irq/overrun and async reset.
module tb_pio_scan_ctrl;
`ifdef PIO_SCAN_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd0;
  logic        irq_clr = 1'b0;
  logic [3:0]  stable_data;
  logic        change, overrun, irq;
  logic [3:0]  in_port = 4'h0;
  int          checks = 0;
  int          failures = 0;
  int          first, prev, n;

  pio_scan_ctrl_if bus();

  pio_scan_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .period      (period),
    .bus         (bus),
    .stable_data (stable_data),
    .change      (change),
    .overrun     (overrun),
    .irq         (irq),
    .irq_clr     (irq_clr)
  );

  always #5 clk = ~clk;

  // 4-bit input PIO slave: registered read, input field at address 0, zero elsewhere
  always @(posedge clk) begin
    bus.pio_readdata <= (bus.pio_address == 2'd0) ? {28'h0, in_port} : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    bus.host_req  = 1'b0;
    bus.host_addr = 2'd0;

    // Reset state
    period  = 16'd9;
    in_port = 4'hA;
    repeat (3) @(negedge clk);
    check("rst_pio_address", bus.pio_address, 0);
    check("rst_host_ack", bus.host_ack, 0);
    check("rst_host_rdata", bus.host_rdata, 0);
    check("rst_stable", stable_data, 0);
    check("rst_change", change, 0);
    check("rst_overrun", overrun, 0);
    check("rst_irq", irq, 0);

    // Test 1: period 9, input held at A; captures at c12/c22/c32, change in c33
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    first = -1; n = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (change) begin
        n++;
        if (first < 0) first = i;
      end
    end
    check("t1_change_cycle", first, 33);
    check("t1_change_count", n, 1);
    check("t1_stable", stable_data, 4'hA);
    check("t1_irq", irq, IRQ_ON);
    check("t1_overrun", overrun, 0);

    // Test 2: period 4 (scan every 5 cycles), input toggles every cycle so samples alternate 5/6
    enable  = 1'b0;
    reset_n = 1'b0;
    period  = 16'd4;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    enable  = 1'b1;
    in_port = 4'h5;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      in_port = (in_port == 4'h5) ? 4'h6 : 4'h5;
      if (change) n++;
    end
    check("t2_change_count", n, 0);
    check("t2_stable", stable_data, 0);

    // Test 3: period 0 with host held; host grant c0, scan c3, host c6 ... ack every 6 cycles
    enable  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    in_port = 4'hA;
    period  = 16'd0;
    @(negedge clk);
    enable        = 1'b1;
    bus.host_addr = 2'd0;
    bus.host_req  = 1'b1;
    first = -1; prev = 0; n = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (bus.host_ack) begin
        n++;
        if (first < 0) first = i;
        else check("t3_ack_gap", i - prev, 6);
        prev = i;
        check("t3_host_rdata", bus.host_rdata, 32'h0000000A);
      end
    end
    check("t3_first_ack", first, 3);
    check("t3_ack_count", n, 4);
    check("t3_stable", stable_data, 4'hA);
    check("t3_overrun", overrun, 1);
    check("t3_irq", irq, IRQ_ON);
    bus.host_req = 1'b0;
    enable       = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_overrun_sticky", overrun, 1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("t3_overrun_clr", overrun, 0);
    check("t3_irq_clr", irq, 0);

    // Test 4: host read of address 1 with scanning disabled
    bus.host_addr = 2'd1;
    bus.host_req  = 1'b1;
    first = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) check("t4_pio_address", bus.pio_address, 1);
      if (bus.host_ack) begin
        if (first < 0) first = i;
        check("t4_host_rdata", bus.host_rdata, 0);
        bus.host_req = 1'b0;
      end
    end
    check("t4_ack_cycle", first, 3);

    // Test 5: reset in the third SCAN_CAP (c17) just before change would pulse
    period  = 16'd4;
    in_port = 4'h3;
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (change) n++;
    end
    reset_n = 1'b0;
    #1;
    check("t5_no_early_change", n, 0);
    check("t5_rst_stable", stable_data, 0);
    check("t5_rst_change", change, 0);
    check("t5_rst_host_ack", bus.host_ack, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (change) n++;
    end
    check("t5_change_in_reset", n, 0);
    reset_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (change && first < 0) first = i;
    end
    check("t5_resume_change_cycle", first, 18);
    check("t5_resume_stable", stable_data, 4'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
